unlock_guard: RTL

Attempt supervisor directly downstream of the combination-lock top level. It consumes the lock's unlock-result level each time the user submits a combination. It opens the lock for a bounded time, counts consecutive failures and enforces a timed lockout after too many failures. It also pulses a reset back to the combination-entry stages after every accepted attempt, so the next entry starts from zero.

---
 rtl/lock_pkg.sv | 17 +
 rtl/unlock_guard_if.sv | 39 +++
 rtl/guard_timer.sv | 30 +++
 rtl/unlock_guard.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and default constants for the unlock_guard attempt supervisor.
// The ALARM encoding is always declared; it is only reachable when UNLOCK_GUARD_ALARM_EN is defined.
package lock_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2,
    ALARM   = 2'd3
  } state_t;

  localparam int DEF_MAX_TRIES      = 3;
  localparam int DEF_LOCKOUT_CYCLES = 1000;
  localparam int DEF_OPEN_CYCLES    = 500;
  localparam int DEF_TIMER_W        = 16;

endpackage

// File: rtl/unlock_guard_if.sv
// Attempt/result bundle between the combination-lock top level and unlock_guard.
// Handshake: SUBMIT is a one-cycle strobe with RES valid in the same cycle; there is no back-pressure.
// The alarm signal exists only when UNLOCK_GUARD_ALARM_EN is defined.
interface unlock_guard_if #(
    parameter int MAX_TRIES = 3
) ();
    localparam int TW = $clog2(MAX_TRIES + 1);

    logic          SUBMIT;
    logic          RES;
    logic          RELOCK;
    logic          CLR;
    logic          unlocked;
    logic          locked_out;
    logic [TW-1:0] tries_left;
    logic          combo_rst;
    logic [1:0]    state;
`ifdef UNLOCK_GUARD_ALARM_EN
    logic          alarm;

    modport master (
        output SUBMIT, RES, RELOCK, CLR,
        input  unlocked, locked_out, tries_left, combo_rst, state, alarm
    );
    modport slave (
        input  SUBMIT, RES, RELOCK, CLR,
        output unlocked, locked_out, tries_left, combo_rst, state, alarm
    );
`else
    modport master (
        output SUBMIT, RES, RELOCK, CLR,
        input  unlocked, locked_out, tries_left, combo_rst, state
    );
    modport slave (
        input  SUBMIT, RES, RELOCK, CLR,
        output unlocked, locked_out, tries_left, combo_rst, state
    );
`endif
endinterface

// File: rtl/guard_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT intervals.
// Load wins over decrement; the caller only enables counting while the value is non-zero.
module guard_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] value_o,
    output logic         zero_o
);

    logic [W-1:0] value_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            value_q <= '0;
        end else if (load_i) begin
            value_q <= load_val_i;
        end else if (en_i) begin
            value_q <= value_q - W'(1);
        end
    end

    assign value_o = value_q;
    assign zero_o  = (value_q == '0);

endmodule

// File: rtl/unlock_guard.sv
// Attempt supervisor: opens the lock for a bounded time, counts failures, enforces timed lockout.
// Define UNLOCK_GUARD_ALARM_EN to escalate a second consecutive lockout into a latched ALARM.
module unlock_guard
    import lock_pkg::*;
#(
    parameter int MAX_TRIES      = DEF_MAX_TRIES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int TIMER_W        = DEF_TIMER_W
) (
    input  logic           CLK,
    input  logic           RST,
    unlock_guard_if.slave  bus
);

    localparam int FW = $clog2(MAX_TRIES + 1);

    state_t               state_q, state_d, cur;
    logic [FW-1:0]        fails_q, fails_d;
    logic                 combo_q, combo_d;
    logic                 tmr_load;
    logic [TIMER_W-1:0]   tmr_load_val;
    logic [TIMER_W-1:0]   tmr_value;
    logic                 tmr_zero;
    logic                 tmr_en;
`ifdef UNLOCK_GUARD_ALARM_EN
    logic [1:0]           lo_cnt_q, lo_cnt_d;

    assign cur = state_q;
`else
    // Encoding 3 cannot be reached here; treat it as ARMED if it ever appears.
    assign cur = (state_q == ALARM) ? ARMED : state_q;
`endif

    guard_timer #(.W(TIMER_W)) u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .value_o    (tmr_value),
        .zero_o     (tmr_zero)
    );

    assign tmr_en = ((cur == OPEN) || (cur == LOCKOUT)) && (tmr_value != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ARMED;
            fails_q  <= '0;
            combo_q  <= 1'b0;
`ifdef UNLOCK_GUARD_ALARM_EN
            lo_cnt_q <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            fails_q  <= fails_d;
            combo_q  <= combo_d;
`ifdef UNLOCK_GUARD_ALARM_EN
            lo_cnt_q <= lo_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d      = cur;
        fails_d      = fails_q;
        combo_d      = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
`ifdef UNLOCK_GUARD_ALARM_EN
        lo_cnt_d     = lo_cnt_q;
`endif
        if (bus.CLR) begin
            state_d  = ARMED;
            fails_d  = '0;
            tmr_load = 1'b1;
`ifdef UNLOCK_GUARD_ALARM_EN
            lo_cnt_d = 2'd0;
`endif
        end else begin
            case (cur)
                OPEN: begin
                    if (bus.RELOCK || tmr_zero) state_d = ARMED;
                end
                LOCKOUT: begin
                    if (tmr_zero) begin
                        fails_d = '0;
`ifdef UNLOCK_GUARD_ALARM_EN
                        state_d = (lo_cnt_q >= 2'd2) ? ALARM : ARMED;
`else
                        state_d = ARMED;
`endif
                    end
                end
`ifdef UNLOCK_GUARD_ALARM_EN
                ALARM: begin
                    state_d = ALARM;
                end
`endif
                default: begin
                    // RELOCK outranks SUBMIT, so an attempt coinciding with it is dropped.
                    if (bus.SUBMIT && !bus.RELOCK) begin
                        combo_d = 1'b1;
                        if (bus.RES) begin
                            state_d      = OPEN;
                            fails_d      = '0;
                            tmr_load     = 1'b1;
                            tmr_load_val = TIMER_W'(OPEN_CYCLES - 1);
`ifdef UNLOCK_GUARD_ALARM_EN
                            lo_cnt_d     = 2'd0;
`endif
                        end else if (int'(fails_q) + 1 < MAX_TRIES) begin
                            fails_d = fails_q + FW'(1);
                        end else begin
                            state_d      = LOCKOUT;
                            fails_d      = FW'(MAX_TRIES);
                            tmr_load     = 1'b1;
                            tmr_load_val = TIMER_W'(LOCKOUT_CYCLES - 1);
`ifdef UNLOCK_GUARD_ALARM_EN
                            if (lo_cnt_q != 2'd3) lo_cnt_d = lo_cnt_q + 2'd1;
`endif
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.unlocked   = (cur == OPEN);
        bus.locked_out = (cur == LOCKOUT) || (cur == ALARM);
        bus.tries_left = FW'(MAX_TRIES) - fails_q;
        bus.combo_rst  = combo_q;
        bus.state      = cur;
`ifdef UNLOCK_GUARD_ALARM_EN
        bus.alarm      = (cur == ALARM);
`endif
    end

endmodule
